// File: rtl/hmac_pkg.sv
// hmac_pkg: shared constants and types for the HMAC message loader.
// Block geometry, SHA-3 domain padding bytes and loader states.
package hmac_pkg;
  localparam int BLOCK_BYTES   = 136;
  localparam int MAX_MSG_BYTES = 135;
  localparam int BLOCK_W       = 8 * BLOCK_BYTES;
  localparam int MAC_W         = 256;

  localparam logic [7:0] SHA3_PAD_FIRST = 8'h60;
  localparam logic [7:0] SHA3_PAD_LAST  = 8'h01;

  typedef enum logic [2:0] {
    LOAD,
    DRAIN,
    PAD,
    START,
    BUSY
  } loader_state_e;
endpackage

// File: rtl/hmac_pad_gen.sv
// hmac_pad_gen: SHA-3 pad mask for a message of cnt bytes.
// 0x60 lands on byte cnt, 0x01 on the final byte; they merge at cnt=135.
module hmac_pad_gen
  import hmac_pkg::*;
(
  input  logic [7:0]         cnt,
  output logic [BLOCK_W-1:0] pad_mask
);
  logic [7:0]  idx;
  logic [10:0] sh;

  always_comb begin
    idx = 8'(MAX_MSG_BYTES) - cnt;
    sh  = {idx, 3'b000};
    pad_mask = ({{(BLOCK_W-8){1'b0}}, SHA3_PAD_FIRST} << sh)
             | {{(BLOCK_W-8){1'b0}}, SHA3_PAD_LAST};
  end
endmodule

// File: rtl/hmac_msg_loader.sv
// hmac_msg_loader: packs a byte stream into one padded SHA3-256 block.
// HMAC_LOADER_ZEROIZE_EN wipes key and block after completion or error.
module hmac_msg_loader
  import hmac_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic               in_empty,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] hmac_key,
  output logic [BLOCK_W-1:0] hmac_message,
  output logic               hmac_start,
  input  logic               hmac_ready,
  input  logic [MAC_W-1:0]   hmac_mac,
  output logic [MAC_W-1:0]   mac_out,
  output logic               mac_valid,
  output logic               err
);
  loader_state_e      state;
  logic [7:0]         cnt;
  logic [BLOCK_W-1:0] pad_mask;
  logic [BLOCK_W-1:0] byte_blk;
  logic [BLOCK_W-1:0] load_blk;
  logic [7:0]         idx;
  logic [10:0]        sh;
  logic               accept;
  logic               has_byte;
  logic               at_max;

  hmac_pad_gen u_pad (
    .cnt      (cnt),
    .pad_mask (pad_mask)
  );

  always_comb begin
    accept   = in_valid & in_ready;
    has_byte = ~(in_last & in_empty);
    at_max   = (cnt == 8'(MAX_MSG_BYTES));
    idx      = 8'(MAX_MSG_BYTES) - cnt;
    sh       = {idx, 3'b000};
    byte_blk = {{(BLOCK_W-8){1'b0}}, in_data} << sh;
    load_blk = (cnt == 8'd0) ? '0 : hmac_message;
    if (has_byte) load_blk = load_blk | byte_blk;
  end

`ifdef HMAC_LOADER_ZEROIZE_EN
  logic wipe;

  always_comb begin
    wipe = 1'b0;
    if (state == BUSY && hmac_ready) wipe = 1'b1;
    if (state == DRAIN && accept && in_last) wipe = 1'b1;
    if (state == LOAD && accept && at_max && has_byte && in_last)
      wipe = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      cnt          <= '0;
      in_ready     <= 1'b0;
      hmac_key     <= '0;
      hmac_message <= '0;
      hmac_start   <= 1'b0;
      mac_out      <= '0;
      mac_valid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      hmac_start <= 1'b0;
      mac_valid  <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (cnt == 8'd0) hmac_key <= key_in;
            // a 136th data byte cannot fit alongside the pad byte
            if (at_max && has_byte) begin
              cnt <= '0;
              if (in_last) err <= 1'b1;
              else state <= DRAIN;
            end else begin
              hmac_message <= load_blk;
              if (has_byte) cnt <= cnt + 8'd1;
              if (in_last) begin
                state    <= PAD;
                in_ready <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          in_ready <= 1'b1;
          if (accept && in_last) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        PAD: begin
          hmac_message <= hmac_message | pad_mask;
          hmac_start   <= 1'b1;
          state        <= START;
        end
        START: begin
          state <= BUSY;
        end
        BUSY: begin
          if (hmac_ready) begin
            mac_out   <= hmac_mac;
            mac_valid <= 1'b1;
            cnt       <= '0;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
`ifdef HMAC_LOADER_ZEROIZE_EN
      if (wipe) begin
        hmac_key     <= '0;
        hmac_message <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_hmac_msg_loader.sv
// tb_hmac_msg_loader: directed messages with a queue-based scoreboard.
// An HMAC stub answers each start with A5..A5 five cycles later.
module tb_hmac_msg_loader;
  import hmac_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [BLOCK_W-1:0] key_in = '0;
  logic [7:0]         in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               in_empty = 1'b0;
  logic               in_ready;
  logic [BLOCK_W-1:0] hmac_key;
  logic [BLOCK_W-1:0] hmac_message;
  logic               hmac_start;
  logic               hmac_ready;
  logic [MAC_W-1:0]   hmac_mac;
  logic [MAC_W-1:0]   mac_out;
  logic               mac_valid;
  logic               err;

  hmac_msg_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_empty     (in_empty),
    .in_ready     (in_ready),
    .hmac_key     (hmac_key),
    .hmac_message (hmac_message),
    .hmac_start   (hmac_start),
    .hmac_ready   (hmac_ready),
    .hmac_mac     (hmac_mac),
    .mac_out      (mac_out),
    .mac_valid    (mac_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  localparam logic [MAC_W-1:0]   MAC_A5 = {32{8'hA5}};
  localparam logic [BLOCK_W-1:0] KEY_A  = {34{32'hDEADBEEF}};
  localparam logic [BLOCK_W-1:0] KEY_B  = {68{16'h1234}};
  localparam logic [BLOCK_W-1:0] KEY_C  = {34{32'h0F1E2D3C}};
  localparam logic [BLOCK_W-1:0] KEY_D  = {136{8'h5A}};
  localparam logic [BLOCK_W-1:0] KEY_E  = {17{64'h0123456789ABCDEF}};
  localparam logic [BLOCK_W-1:0] BLK_ABC =
    {8'h61, 8'h62, 8'h63, 8'h60, {131{8'h00}}, 8'h01};
  localparam logic [BLOCK_W-1:0] BLK_EMPTY =
    {8'h60, {134{8'h00}}, 8'h01};

  int errors = 0;
  int checks = 0;
  int err_exp = 0;
  int stall_first = 0;
  logic [BLOCK_W-1:0] start_key_q[$];
  logic [BLOCK_W-1:0] start_msg_q[$];
  logic [MAC_W-1:0]   mac_q[$];
  logic [BLOCK_W-1:0] last_start_msg = '0;

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act,
                     input logic [BLOCK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_msg(input logic [7:0] b[$], input bit empty_last,
                          input logic [BLOCK_W-1:0] key,
                          input logic [BLOCK_W-1:0] exp_msg,
                          input bit expect_start);
    int nb;
    int t;
    nb = empty_last ? b.size() + 1 : b.size();
    if (expect_start) begin
      start_key_q.push_back(key);
      start_msg_q.push_back(exp_msg);
    end else begin
      err_exp++;
    end
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (i < b.size()) ? b[i] : 8'h00;
      in_last  = (i == nb - 1);
      in_empty = empty_last && (i == nb - 1);
      key_in   = key;
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (i == 0) stall_first = t;
      if (t >= 200) begin
        errors++;
        checks++;
        $display("FAIL beat_timeout: in_ready stuck 0 beat %0d", i);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
    if (expect_start) begin
      chk("pad_no_start", hmac_start, 1'b0);
    end else begin
      chk("err_pulse", err, 1'b1);
      chk("drain_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    chk("start_at_t2", hmac_start, expect_start);
    @(negedge clk);
    chk("start_one_cycle", hmac_start, 1'b0);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hmac_start) begin
          if (start_key_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got 1 want 0");
          end else begin
            chk("start_key", hmac_key, start_key_q.pop_front());
            last_start_msg = start_msg_q.pop_front();
            chk("start_msg", hmac_message, last_start_msg);
          end
        end
        if (err) begin
          checks++;
          if (err_exp == 0) begin
            errors++;
            $display("FAIL unexpected_err: got 1 want 0");
          end else begin
            err_exp--;
          end
`ifdef HMAC_LOADER_ZEROIZE_EN
          chk("err_zero_msg", hmac_message, '0);
          chk("err_zero_key", hmac_key, '0);
`endif
        end
        if (mac_valid) begin
          if (mac_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mac_valid: got 1 want 0");
          end else begin
            chk("mac_out", mac_out, mac_q.pop_front());
          end
`ifdef HMAC_LOADER_ZEROIZE_EN
          chk("zero_msg", hmac_message, '0);
          chk("zero_key", hmac_key, '0);
`else
          chk("msg_retained", hmac_message, last_start_msg);
`endif
        end
      end
    end
  end

  // HMAC stub
  initial begin
    int sc;
    bit pend;
    sc = 0;
    pend = 1'b0;
    hmac_ready = 1'b0;
    hmac_mac = '0;
    forever begin
      @(negedge clk);
      hmac_ready = 1'b0;
      if (pend) begin
        chk("mac_valid_r1", mac_valid, 1'b1);
        chk("ready_r1", in_ready, 1'b1);
        pend = 1'b0;
      end
      if (!rst_n) begin
        sc = 0;
      end else if (sc > 0) begin
        sc--;
        if (sc == 0) begin
          hmac_ready = 1'b1;
          hmac_mac = MAC_A5;
          mac_q.push_back(MAC_A5);
          pend = 1'b1;
        end
      end else if (hmac_start) begin
        sc = 5;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_key"}, hmac_key, '0);
    chk({tag, "_msg"}, hmac_message, '0);
    chk({tag, "_start"}, hmac_start, 1'b0);
    chk({tag, "_mac"}, mac_out, '0);
    chk({tag, "_macv"}, mac_valid, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    logic [7:0] abc[$];
    logic [7:0] none[$];
    logic [7:0] m135[$];
    logic [7:0] m137[$];
    logic [BLOCK_W-1:0] blk135;
    int t;
    abc = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 135; i++) m135.push_back(8'(i));
    for (int i = 0; i < 137; i++) m137.push_back(8'(i + 16));
    blk135 = '0;
    for (int i = 0; i < 135; i++) blk135[BLOCK_W-1-8*i -: 8] = 8'(i);
    blk135[7:0] = 8'h61;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1'b1);

    send_msg(abc, 1'b0, KEY_A, BLK_ABC, 1'b1);
    send_msg(none, 1'b1, KEY_B, BLK_EMPTY, 1'b1);
    chk("busy_stall", stall_first > 0, 1'b1);
    send_msg(m135, 1'b0, KEY_C, blk135, 1'b1);
    send_msg(m137, 1'b0, KEY_D, '0, 1'b0);
    send_msg(abc, 1'b0, KEY_E, BLK_ABC, 1'b1);

    // reset while the previous message is in BUSY
    send_msg(abc, 1'b0, KEY_A, BLK_ABC, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midbusy");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_msg(abc, 1'b0, KEY_B, BLK_ABC, 1'b1);

    t = 0;
    while ((mac_q.size() != 0 || start_key_q.size() != 0 || !in_ready)
           && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("start_q_drained", 32'(start_key_q.size()), 32'd0);
    chk("mac_q_drained", 32'(mac_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_exp), 32'd0);
    chk("final_mac", mac_out, MAC_A5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
